cache_dm_wt: RTL and testbench
==============================

# cache_dm_wt

Parametrised direct-mapped, write-through, no-write-allocate cache sitting between a single requester and the `ram` backing memory. It extends the read-only 64-entry cache with configurable data, address and index widths. It also adds writes, a valid/ready request handshake, an explicit memory handshake, asynchronous reset and flush. Hits return in one cycle. Misses and all writes go to memory and complete one cycle after `mem_ack`.

## Interface
- `DATA_W`, 32: data word width.
- `ADDR_W`, 12: word address width.
- `INDEX_W`, 6: index width. Depth is 2**INDEX_W. TAG_W is ADDR_W-INDEX_W and must be ≥1.
- `STAT_W`, 16: statistics counter width. Used only with `CACHE_DM_WT_STATS_EN`.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `flush` in 1: invalidate all lines.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out DATA_W: read data, valid with `resp_valid` on reads.
- `resp_hit` out 1: the request hit.
- `mem_req` out 1: memory access request, held until `mem_ack`.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle memory completion.
- `hit_count`, `miss_count` out STAT_W: present only with `CACHE_DM_WT_STATS_EN`.

## Operation
- Address split: index = `req_addr[INDEX_W-1:0]`, tag = `req_addr[ADDR_W-1:INDEX_W]`. Request fields are registered on acceptance.
- States:
  - IDLE → LOOKUP on accept (`req_valid && req_ready`).
  - LOOKUP → IDLE on read hit.
  - LOOKUP → MEM_RD on read miss.
  - LOOKUP → MEM_WR on any write.
  - MEM_RD/MEM_WR → RESP on `mem_ack`.
  - RESP → IDLE.
- `req_ready` = 1 only in IDLE with `flush` = 0.
- Read hit: `resp_valid`=1, `resp_hit`=1, `resp_rdata` = line data. No memory access.
- Read miss:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = registered address.
  - On `mem_ack`: line data ← `mem_rdata`, tag written, valid set.
  - RESP returns `mem_rdata` with `resp_hit`=0.
- Write: always issues `mem_req`=1, `mem_we`=1 with the registered address and data.
  - On a hit, the line data is updated at `mem_ack`.
  - On a miss, the cache is unchanged (no allocate).
  - RESP: `resp_rdata` = 0, `resp_hit` = lookup result.
- Flush: in IDLE, clears every valid bit in one cycle. Tags and data are untouched. Flush wins over a simultaneous `req_valid`, which is not accepted that cycle. Outside IDLE, `flush` is ignored.
- Memory outputs are driven only in MEM_RD/MEM_WR and are 0 otherwise. `mem_ack` outside those states is ignored.

## Timing
- Reset values:
  - state IDLE, all valid bits 0.
  - `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_hit`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - counters 0.
- Read hit: accepted at edge N, `resp_valid` high during cycle N+1, `req_ready` back high at N+2.
- Miss or write: `mem_req` rises in cycle N+2. If `mem_ack` is sampled at edge M, `resp_valid` is high during cycle M+1. Minimum total latency is 3 cycles.
- `resp_valid` is a single-cycle pulse with no backpressure.
- Reset mid-miss or mid-write:
  - state returns to IDLE and `mem_req` drops immediately.
  - no response is issued.
  - a later stray `mem_ack` is ignored.
- Back-to-back accesses to the same index with different tags replace the line on each read miss.

## Configuration
- `CACHE_DM_WT_STATS_EN` defined: adds `hit_count` and `miss_count` ports.
  - Each increments by 1 in the LOOKUP cycle of a read hit or read miss respectively. Writes are not counted.
  - Both saturate at 2**STAT_W-1.
  - Both are cleared by reset, but not by flush.
- Not defined: ports and counters are absent. All other behaviour is identical.

## Structure
- Package `cache_dm_wt_pkg` holds:
  - the state enum (IDLE, LOOKUP, MEM_RD, MEM_WR, RESP).
  - tag/index extraction functions parametrised on ADDR_W and INDEX_W.
- Sub-module `cache_tag_store`:
  - valid, tag and data arrays.
  - one combinational read port at the registered index.
  - one write port.
  - flush-all clear.
  - async reset of the valid bits.

## Test plan
- After reset, read address 0x041 with `mem_rdata`=0xDEADBEEF and ack 2 cycles after `mem_req` → `resp_hit`=0, `resp_rdata`=0xDEADBEEF. A repeat read → `resp_hit`=1, same data one cycle after accept, no `mem_req`.
- Read 0x041 then read 0x081 (same index 1, new tag) → both miss. Read 0x041 again → misses.
- Fill 0x041, then write 0x041 with 0x12345678 → `mem_we`=1 with matching address and data, `resp_hit`=1. A subsequent read hits and returns 0x12345678.
- Write 0x0C2 without a prior fill → memory write issued, `resp_hit`=0. A following read of 0x0C2 misses.
- Fill 0x041, pulse `flush` together with `req_valid` → request not accepted that cycle. Read 0x041 next → miss.
- Assert `rst` while in MEM_RD → `mem_req` drops immediately and no `resp_valid` occurs. A later `mem_ack` is ignored. With the stats macro, counters read 0.

Source files
------------

// File: rtl/cache_dm_wt_pkg.sv
//==============================================================================
// Module      : cache_dm_wt_pkg
// Description : State encoding and address-split helpers for cache_dm_wt.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cache_dm_wt_pkg;

    localparam int c_ADDR_MAX_W = 64;

    typedef logic [c_ADDR_MAX_W-1:0] addr_ext_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // Callers zero-extend the address in and truncate the result to their width.
    function automatic addr_ext_t f_index(input addr_ext_t addr, input int index_w);
        return addr & ((addr_ext_t'(1) << index_w) - addr_ext_t'(1));
    endfunction

    function automatic addr_ext_t f_tag(input addr_ext_t addr, input int addr_w, input int index_w);
        return (addr & ((addr_ext_t'(1) << addr_w) - addr_ext_t'(1))) >> index_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_tag_store.sv
//==============================================================================
// Module      : cache_tag_store
// Description : Valid/tag/data arrays with one async read port, one write port
//               and single-cycle flush of all valid bits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_tag_store #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6,
    parameter int INDEX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_valid,
    output logic [TAG_W-1:0]   o_tag,
    output logic [DATA_W-1:0]  o_data,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [DATA_W-1:0]  i_wr_data
);

    localparam int c_DEPTH = 1 << INDEX_W;

    logic [c_DEPTH-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [c_DEPTH];
    logic [DATA_W-1:0]  r_data [c_DEPTH];

    // Only the valid bits are reset; stale tags/data are harmless behind them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_valid = r_valid[i_rd_index];
    assign o_tag   = r_tag[i_rd_index];
    assign o_data  = r_data[i_rd_index];

endmodule

`default_nettype wire

// File: rtl/cache_dm_wt.sv
//==============================================================================
// Module      : cache_dm_wt
// Description : Direct-mapped, write-through, no-write-allocate cache.
//               Optional hit/miss counters with CACHE_DM_WT_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_dm_wt
    import cache_dm_wt_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int INDEX_W = 6,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_DM_WT_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    localparam int c_TAG_W = ADDR_W - INDEX_W;

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_hit;

    logic [INDEX_W-1:0]  w_index;
    logic [c_TAG_W-1:0]  w_tag;
    logic                w_line_valid;
    logic [c_TAG_W-1:0]  w_line_tag;
    logic [DATA_W-1:0]   w_line_data;
    logic                w_hit;
    logic                w_rd_hit;
    logic                w_st_we;
    logic [DATA_W-1:0]   w_st_wdata;
    logic                w_flush;

    assign w_index = INDEX_W'(f_index(addr_ext_t'(r_addr), INDEX_W));
    assign w_tag   = c_TAG_W'(f_tag(addr_ext_t'(r_addr), ADDR_W, INDEX_W));

    assign w_hit    = w_line_valid && (w_line_tag == w_tag);
    assign w_rd_hit = (r_state == S_LOOKUP) && !r_we && w_hit;
    assign w_flush  = (r_state == S_IDLE) && flush;

    // Fills always allocate; writes only refresh a line that already holds this tag.
    assign w_st_we    = mem_ack && ((r_state == S_MEM_RD) || ((r_state == S_MEM_WR) && r_hit));
    assign w_st_wdata = (r_state == S_MEM_RD) ? mem_rdata : r_wdata;

    cache_tag_store #(
        .DATA_W  (DATA_W),
        .TAG_W   (c_TAG_W),
        .INDEX_W (INDEX_W)
    ) u_tag_store (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (w_flush),
        .i_rd_index (w_index),
        .o_valid    (w_line_valid),
        .o_tag      (w_line_tag),
        .o_data     (w_line_data),
        .i_we       (w_st_we),
        .i_wr_index (w_index),
        .i_wr_tag   (w_tag),
        .i_wr_data  (w_st_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        r_state <= S_LOOKUP;
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                    end
                end
                S_LOOKUP: begin
                    r_hit <= w_hit;
                    if (r_we) begin
                        r_state <= S_MEM_WR;
                    end else if (w_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_MEM_RD;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ack) begin
                        r_rdata <= mem_rdata;
                        r_state <= S_RESP;
                    end
                end
                S_MEM_WR: begin
                    if (mem_ack) begin
                        r_rdata <= '0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Hits answer straight from the array during LOOKUP; everything else from RESP.
    assign req_ready  = (r_state == S_IDLE) && !flush;
    assign resp_valid = w_rd_hit || (r_state == S_RESP);
    assign resp_hit   = w_rd_hit || ((r_state == S_RESP) && r_hit);
    assign resp_rdata = w_rd_hit ? w_line_data :
                        (r_state == S_RESP) ? r_rdata : '0;

    assign mem_req   = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign mem_we    = (r_state == S_MEM_WR);
    assign mem_addr  = mem_req ? r_addr : '0;
    assign mem_wdata = mem_we ? r_wdata : '0;

`ifdef CACHE_DM_WT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((r_state == S_LOOKUP) && !r_we) begin
            if (w_hit) begin
                if (hit_count != '1) begin
                    hit_count <= hit_count + STAT_W'(1);
                end
            end else if (miss_count != '1) begin
                miss_count <= miss_count + STAT_W'(1);
            end
        end
    end
`else
    logic w_unused_stat;
    assign w_unused_stat = (STAT_W > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_dm_wt.sv
//==============================================================================
// Module      : tb_cache_dm_wt
// Description : Self-checking bench for cache_dm_wt: transaction-level cache
//               and memory model, per-cycle output compare, random traffic.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_dm_wt;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 12;
    localparam int INDEX_W = 6;
    localparam int STAT_W  = 16;
    localparam int TAG_W   = ADDR_W - INDEX_W;
    localparam int DEPTH   = 1 << INDEX_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              flush;
    logic              resp_valid, resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_ack;
`ifdef CACHE_DM_WT_STATS_EN
    logic [STAT_W-1:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_dm_wt #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .INDEX_W (INDEX_W), .STAT_W (STAT_W)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_addr (req_addr), .req_wdata (req_wdata), .flush (flush),
        .resp_valid (resp_valid), .resp_rdata (resp_rdata), .resp_hit (resp_hit),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .mem_ack (mem_ack)
`ifdef CACHE_DM_WT_STATS_EN
        , .hit_count (hit_count), .miss_count (miss_count)
`endif
    );

    // Expected outputs for the current cycle
    logic              e_ready, e_rv, e_hit, e_mreq, e_mwe;
    logic [DATA_W-1:0] e_rdata, e_mwdata;
    logic [ADDR_W-1:0] e_maddr;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: backing memory plus cache contents by line
    logic [DATA_W-1:0] mem     [1 << ADDR_W];
    bit                m_valid [DEPTH];
    logic [TAG_W-1:0]  m_tag   [DEPTH];
    logic [DATA_W-1:0] m_data  [DEPTH];
    int                m_hits, m_misses;

    logic [DATA_W-1:0] last_rdata;
    logic              last_hit;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("req_ready",  64'(req_ready),  64'(e_ready));
            cmp("resp_valid", 64'(resp_valid), 64'(e_rv));
            cmp("resp_hit",   64'(resp_hit),   64'(e_hit));
            cmp("resp_rdata", 64'(resp_rdata), 64'(e_rdata));
            cmp("mem_req",    64'(mem_req),    64'(e_mreq));
            cmp("mem_we",     64'(mem_we),     64'(e_mwe));
            cmp("mem_addr",   64'(mem_addr),   64'(e_maddr));
            if (e_mwe) cmp("mem_wdata", 64'(mem_wdata), 64'(e_mwdata));
            if (resp_valid) begin
                last_rdata = resp_rdata;
                last_hit   = resp_hit;
            end
        end
    end

    task automatic set_idle();
        e_ready = 1'b1; e_rv = 1'b0; e_hit = 1'b0; e_rdata = '0;
        e_mreq = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_mwdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_req(input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int dly);
        int                idx;
        logic [TAG_W-1:0]  tg;
        bit                hit;
        logic [DATA_W-1:0] rd;
        idx = int'(addr) % DEPTH;
        tg  = TAG_W'(int'(addr) / DEPTH);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        last_hit = 1'bx; last_rdata = 'x;
        set_idle();
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = $urandom;
        set_idle(); e_ready = 1'b0;
        if (!we && hit) begin
            e_rv = 1'b1; e_hit = 1'b1; e_rdata = m_data[idx];
            m_hits++;
            tick();
            set_idle();
            return;
        end
        if (!we) m_misses++;
        tick();
        e_mreq = 1'b1; e_mwe = we; e_maddr = addr; e_mwdata = wdata;
        repeat (dly) tick();
        rd = mem[addr];
        mem_ack = 1'b1;
        mem_rdata = we ? $urandom : rd;
        tick();
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (we) begin
            mem[addr] = wdata;
            if (hit) m_data[idx] = wdata;
        end else begin
            m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = rd;
        end
        set_idle(); e_ready = 1'b0; e_rv = 1'b1;
        e_hit   = we ? hit : 1'b0;
        e_rdata = we ? '0 : rd;
        tick();
        set_idle();
    endtask

    task automatic do_flush(input bit with_req);
        set_idle(); e_ready = 1'b0;
        flush = 1'b1; req_valid = with_req; req_we = 1'b0; req_addr = ADDR_W'($urandom);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        set_idle();
    endtask

    task automatic stray_ack();
        set_idle();
        mem_ack = 1'b1; mem_rdata = $urandom;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        for (int i = 0; i < DEPTH; i++) begin m_tag[i] = '0; m_data[i] = '0; end
        model_reset();
        set_idle();
        #1;
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Cold miss, then hit
        mem[12'h041] = 32'hDEADBEEF;
        do_req(1'b0, 12'h041, '0, 2);
        cmp("pin_cold_hit",   64'(last_hit),   64'd0);
        cmp("pin_cold_rdata", 64'(last_rdata), 64'hDEADBEEF);
        do_req(1'b0, 12'h041, '0, 0);
        cmp("pin_warm_hit",   64'(last_hit),   64'd1);
        cmp("pin_warm_rdata", 64'(last_rdata), 64'hDEADBEEF);

        // Conflict on index 1
        mem[12'h081] = 32'h0BADF00D;
        do_req(1'b0, 12'h081, '0, 1);
        cmp("pin_conflict_hit",   64'(last_hit),   64'd0);
        cmp("pin_conflict_rdata", 64'(last_rdata), 64'h0BADF00D);
        do_req(1'b0, 12'h041, '0, 0);
        cmp("pin_refill_hit", 64'(last_hit), 64'd0);

        // Write hit updates the line
        do_req(1'b1, 12'h041, 32'h12345678, 1);
        cmp("pin_wr_hit",   64'(last_hit),   64'd1);
        cmp("pin_wr_rdata", 64'(last_rdata), 64'd0);
        do_req(1'b0, 12'h041, '0, 0);
        cmp("pin_after_wr_hit",   64'(last_hit),   64'd1);
        cmp("pin_after_wr_rdata", 64'(last_rdata), 64'h12345678);

        // Write miss does not allocate, but memory is updated
        do_req(1'b1, 12'h0C2, 32'hA5A50C20, 0);
        cmp("pin_wr_miss_hit", 64'(last_hit), 64'd0);
        do_req(1'b0, 12'h0C2, '0, 0);
        cmp("pin_rd_after_wmiss_hit",   64'(last_hit),   64'd0);
        cmp("pin_rd_after_wmiss_rdata", 64'(last_rdata), 64'hA5A50C20);

        // Flush beats a simultaneous request
        do_req(1'b0, 12'h041, '0, 0);
        do_flush(1'b1);
        tick();
        do_req(1'b0, 12'h041, '0, 0);
        cmp("pin_after_flush_hit", 64'(last_hit), 64'd0);

        // Reset while waiting on memory
        set_idle();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h3C5;
        tick();
        req_valid = 1'b0;
        set_idle(); e_ready = 1'b0;
        tick();
        e_mreq = 1'b1; e_maddr = 12'h3C5;
        @(negedge clk);
        #1;
        rst = 1'b1;
        set_idle();
        #1;
        cmp("rst_mem_req_drop", 64'(mem_req), 64'd0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        stray_ack();
        repeat (3) tick();
`ifdef CACHE_DM_WT_STATS_EN
        cmp("rst_hit_count",  64'(hit_count),  64'd0);
        cmp("rst_miss_count", 64'(miss_count), 64'd0);
`endif
        do_req(1'b0, 12'h041, '0, 0);
        cmp("pin_after_rst_hit", 64'(last_hit), 64'd0);

        // Random traffic over a small address pool to force hits and conflicts
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] a;
            int r;
            a = ADDR_W'($urandom_range(0, 3) * DEPTH + $urandom_range(0, 7));
            r = $urandom_range(0, 99);
            if (r < 4) begin
                do_flush(1'($urandom));
            end else if (r < 8) begin
                stray_ack();
            end else begin
                do_req(r < 35, a, $urandom, $urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 1)) tick();
        end

`ifdef CACHE_DM_WT_STATS_EN
        cmp("hit_count",  64'(hit_count),  64'(m_hits));
        cmp("miss_count", 64'(miss_count), 64'(m_misses));
`endif
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
